// File: rtl/regfile_alu_datapath.sv
// ---------------------------------------------------------------------------
// regfile_alu_datapath
//
// Register-file-plus-ALU datapath of the 16-bit processor. It holds eight
// 16-bit general registers (r0..r7, all writable) behind two asynchronous
// read ports and one synchronous write port. A combinational ALU combines
// the two read operands, and a registered zero flag records the outcome of
// the most recent SUB for conditional branches.
//
// Ports
//   clk           in   1   system clock, all state updates on the rising edge
//   rst_n         in   1   asynchronous active-low reset (regs and flag -> 0)
//   address_a     in   3   read port A index, also the write destination
//   address_b     in   3   read port B index
//   write_enable  in   1   write write_data into register[address_a]
//   write_data    in   16  data to write
//   opcode        in   4   ALU operation select (instruction[15:12])
//   data_a        out  16  register[address_a], combinational
//   data_b        out  16  register[address_b], combinational
//   alu_result    out  16  data_a op data_b, combinational
//   alu_zero      out  1   alu_result == 0, combinational
//   zero_flag     out  1   registered zero status, updated only by SUB
// ---------------------------------------------------------------------------
module regfile_alu_datapath (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  address_a,
  input  logic [2:0]  address_b,
  input  logic        write_enable,
  input  logic [15:0] write_data,
  input  logic [3:0]  opcode,
  output logic [15:0] data_a,
  output logic [15:0] data_b,
  output logic [15:0] alu_result,
  output logic        alu_zero,
  output logic        zero_flag
);

  localparam int unsigned NumRegs = 8;
  localparam int unsigned Width   = 16;

  // ALU opcodes; every other encoding (load-immediate, jmp, br, out, unused)
  // produces a zero result.
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0011;
  localparam logic [3:0] OpAnd = 4'b0100;
  localparam logic [3:0] OpOr  = 4'b0101;
  localparam logic [3:0] OpXor = 4'b0110;
  localparam logic [3:0] OpSll = 4'b0111;

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  logic [Width-1:0]   regs_q [NumRegs];
  logic [NumRegs-1:0] reg_we;

  // One-hot write decode of the destination index.
  always_comb begin
    reg_we = '0;
    if (write_enable) begin
      reg_we[address_a] = 1'b1;
    end
  end

  for (genvar g = 0; g < NumRegs; g++) begin : gen_regs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs_q[g] <= '0;
      end else if (reg_we[g]) begin
        regs_q[g] <= write_data;
      end
    end
  end

  // Asynchronous reads with no write bypass: a register being written still
  // reads its old value until the edge.
  assign data_a = regs_q[address_a];
  assign data_b = regs_q[address_b];

  // -------------------------------------------------------------------------
  // ALU
  // -------------------------------------------------------------------------
  always_comb begin
    alu_result = '0;
    case (opcode)
      OpAdd:   alu_result = data_a + data_b;
      OpSub:   alu_result = data_a - data_b;
      OpAnd:   alu_result = data_a & data_b;
      OpOr:    alu_result = data_a | data_b;
      OpXor:   alu_result = data_a ^ data_b;
      OpSll:   alu_result = data_a << data_b[3:0];
      default: alu_result = '0;
    endcase
  end

  assign alu_zero = (alu_result == '0);

  // -------------------------------------------------------------------------
  // Zero status flag: sampled only on SUB, independent of write_enable, so a
  // SUB that writes back still flags on the pre-edge operands.
  // -------------------------------------------------------------------------
  logic zero_flag_q;
  logic zero_flag_d;

  always_comb begin
    zero_flag_d = zero_flag_q;
    if (opcode == OpSub) begin
      zero_flag_d = alu_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_flag_q <= 1'b0;
    end else begin
      zero_flag_q <= zero_flag_d;
    end
  end

  assign zero_flag = zero_flag_q;

endmodule

// File: tb/tb_regfile_alu_datapath.sv
// ---------------------------------------------------------------------------
// tb_regfile_alu_datapath
//
// Directed and randomized bench for regfile_alu_datapath. A behavioural model
// (array of register values, a flag bit and an arithmetic ALU function) is
// stepped alongside the DUT; combinational outputs are sampled mid-cycle and
// the zero flag just after each rising edge.
// ---------------------------------------------------------------------------
module tb_regfile_alu_datapath;

  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0011;
  localparam logic [3:0] OpAnd = 4'b0100;
  localparam logic [3:0] OpOr  = 4'b0101;
  localparam logic [3:0] OpXor = 4'b0110;
  localparam logic [3:0] OpSll = 4'b0111;
  localparam logic [3:0] OpOut = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  aa = '0;
  logic [2:0]  ab = '0;
  logic        we = 1'b0;
  logic [15:0] wd = '0;
  logic [3:0]  op = '0;
  logic [15:0] data_a;
  logic [15:0] data_b;
  logic [15:0] alu_result;
  logic        alu_zero;
  logic        zero_flag;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_regs [8];
  logic        m_flag;

  regfile_alu_datapath dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .address_a    (aa),
    .address_b    (ab),
    .write_enable (we),
    .write_data   (wd),
    .opcode       (op),
    .data_a       (data_a),
    .data_b       (data_b),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .zero_flag    (zero_flag)
  );

  always #5 clk = ~clk;

  // Reference ALU written with plain integer arithmetic modulo 2^16.
  function automatic logic [15:0] ref_alu(input logic [3:0] o, input logic [15:0] a,
                                          input logic [15:0] b);
    int unsigned ua;
    int unsigned ub;
    ua = a;
    ub = b;
    case (o)
      OpAdd:   return 16'((ua + ub) % 65536);
      OpSub:   return 16'((ua + 65536 - ub) % 65536);
      OpAnd:   return a & b;
      OpOr:    return a | b;
      OpXor:   return a ^ b;
      OpSll:   return 16'((ua * (32'd1 << (ub % 16))) % 65536);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_flag = 1'b0;
  endtask

  // Apply inputs shortly after a rising edge and let them settle.
  task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic w,
                       input logic [15:0] d, input logic [3:0] o);
    aa = a;
    ab = b;
    we = w;
    wd = d;
    op = o;
    #1;
  endtask

  // Compare every combinational output and the held flag against the model.
  task automatic check_comb(input string tag);
    logic [15:0] er;
    er = ref_alu(op, m_regs[aa], m_regs[ab]);
    chk({tag, "_data_a"}, data_a, m_regs[aa]);
    chk({tag, "_data_b"}, data_b, m_regs[ab]);
    chk({tag, "_alu_result"}, alu_result, er);
    chk({tag, "_alu_zero"}, {15'b0, alu_zero}, {15'b0, (er == 16'h0000)});
    chk({tag, "_zero_flag_hold"}, {15'b0, zero_flag}, {15'b0, m_flag});
  endtask

  // Advance one clock, updating the model from the pre-edge state.
  task automatic edge_step(input string tag);
    logic [15:0] er;
    er = ref_alu(op, m_regs[aa], m_regs[ab]);
    if (op == OpSub) m_flag = (er == 16'h0000);
    if (we) m_regs[aa] = wd;
    @(posedge clk);
    #1;
    chk({tag, "_zero_flag"}, {15'b0, zero_flag}, {15'b0, m_flag});
  endtask

  initial begin
    model_reset();

    // Reset held with a write request and the clock running.
    we = 1'b1;
    wd = 16'hDEAD;
    aa = 3'd3;
    op = OpSub;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      aa = 3'(i);
      ab = 3'(7 - i);
      #1;
      chk("rst_data_a", data_a, 16'h0000);
      chk("rst_data_b", data_b, 16'h0000);
    end
    chk("rst_zero_flag", {15'b0, zero_flag}, 16'h0000);
    op = OpAdd;
    #1;
    chk("rst_add_result", alu_result, 16'h0000);
    chk("rst_add_zero", {15'b0, alu_zero}, 16'h0001);
    we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First write after reset.
    drive(3'd3, 3'd0, 1'b1, 16'h00AB, 4'b0001);
    check_comb("w_r3");
    edge_step("w_r3");
    drive(3'd3, 3'd0, 1'b0, 16'h5555, 4'b0001);
    check_comb("rd_r3");
    chk("r3_value", data_a, 16'h00AB);
    edge_step("rd_r3");

    // Write every register, then read back on both ports with write disabled.
    for (int i = 0; i < 8; i++) begin
      drive(3'(i), 3'(i), 1'b1, 16'(16'h1111 * i), 4'b0001);
      edge_step("w_all");
    end
    for (int i = 0; i < 8; i++) begin
      drive(3'(i), 3'(7 - i), 1'b0, 16'hFFFF, 4'b0000);
      check_comb("rd_all");
      chk("rd_all_const", data_a, 16'(16'h1111 * i));
      edge_step("rd_all");
    end

    // ADD wrap-around with write-back.
    drive(3'd1, 3'd0, 1'b1, 16'hFFFF, 4'b0001);
    edge_step("w_r1");
    drive(3'd2, 3'd0, 1'b1, 16'h0002, 4'b0001);
    edge_step("w_r2");
    drive(3'd1, 3'd2, 1'b1, 16'h0001, OpAdd);
    check_comb("add_wrap");
    chk("add_wrap_const", alu_result, 16'h0001);
    chk("add_wrap_zero", {15'b0, alu_zero}, 16'h0000);
    edge_step("add_wb");
    drive(3'd1, 3'd2, 1'b0, 16'h0000, 4'b0000);
    chk("add_wb_r1", data_a, 16'h0001);

    // SUB sets the flag, ADD leaves it, SUB with non-zero clears it.
    drive(3'd4, 3'd0, 1'b1, 16'h0005, 4'b0001);
    edge_step("w_r4");
    drive(3'd5, 3'd0, 1'b1, 16'h0005, 4'b0001);
    edge_step("w_r5");
    drive(3'd4, 3'd5, 1'b0, 16'h0000, OpSub);
    check_comb("sub_eq");
    chk("sub_eq_result", alu_result, 16'h0000);
    chk("sub_eq_zero", {15'b0, alu_zero}, 16'h0001);
    edge_step("sub_eq");
    chk("flag_set", {15'b0, zero_flag}, 16'h0001);
    drive(3'd4, 3'd5, 1'b0, 16'h0000, OpAdd);
    check_comb("add_nz");
    edge_step("add_nz");
    chk("flag_hold", {15'b0, zero_flag}, 16'h0001);
    drive(3'd3, 3'd0, 1'b1, 16'h0003, 4'b0001);
    edge_step("w_r3b");
    drive(3'd4, 3'd3, 1'b0, 16'h0000, OpSub);
    check_comb("sub_ne");
    edge_step("sub_ne");
    chk("flag_clr", {15'b0, zero_flag}, 16'h0000);

    // Logic, shift and non-ALU opcodes.
    drive(3'd0, 3'd0, 1'b1, 16'h0F0F, 4'b0001);
    edge_step("w_r0");
    drive(3'd7, 3'd0, 1'b1, 16'h00F3, 4'b0001);
    edge_step("w_r7");
    drive(3'd0, 3'd7, 1'b0, 16'h0000, OpAnd);
    check_comb("and");
    chk("and_const", alu_result, 16'h0003);
    drive(3'd0, 3'd7, 1'b0, 16'h0000, OpOr);
    check_comb("or");
    chk("or_const", alu_result, 16'h0FFF);
    drive(3'd0, 3'd7, 1'b0, 16'h0000, OpXor);
    check_comb("xor");
    chk("xor_const", alu_result, 16'h0FFC);
    drive(3'd0, 3'd7, 1'b0, 16'h0000, OpSll);
    check_comb("sll");
    chk("sll_const", alu_result, 16'h7878);
    drive(3'd0, 3'd7, 1'b0, 16'h0000, OpOut);
    check_comb("out");
    chk("out_const", alu_result, 16'h0000);
    chk("out_zero", {15'b0, alu_zero}, 16'h0001);
    edge_step("logic_end");

    // Set the flag so the mid-cycle reset has something to clear.
    drive(3'd4, 3'd4, 1'b0, 16'h0000, OpSub);
    edge_step("flag_set2");

    // Same address on both ports: old value before the edge, new after.
    drive(3'd6, 3'd6, 1'b1, 16'h1234, 4'b0001);
    check_comb("same_pre");
    chk("same_pre_a", data_a, 16'h6666);
    chk("same_pre_b", data_b, 16'h6666);
    edge_step("same_wr");
    chk("same_post_a", data_a, 16'h1234);
    chk("same_post_b", data_b, 16'h1234);

    // Asynchronous reset pulsed between edges while a write is pending.
    drive(3'd6, 3'd6, 1'b1, 16'hBEEF, OpAdd);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_a", data_a, 16'h0000);
    chk("mid_rst_b", data_b, 16'h0000);
    chk("mid_rst_flag", {15'b0, zero_flag}, 16'h0000);
    we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_comb("post_rst");

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic [3:0]  ro;
      logic [15:0] rd;
      ra = 3'($urandom_range(0, 7));
      rb = 3'($urandom_range(0, 7));
      ro = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                        : 4'($urandom_range(2, 7));
      case ($urandom_range(0, 2))
        0:       rd = ref_alu(ro, m_regs[ra], m_regs[rb]);
        1:       rd = 16'($urandom);
        default: rd = 16'($urandom_range(0, 3));
      endcase
      drive(ra, rb, 1'($urandom_range(0, 1)), rd, ro);
      check_comb("rand");
      edge_step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_alu_datapath.md
# regfile_alu_datapath

Register-file-plus-ALU datapath core of the 16-bit processor. Holds eight 16-bit general registers with two combinational read ports and one write port. Combines two read operands in a combinational ALU selected by the instruction opcode, and keeps a registered zero status flag for conditional branches. The processor's decode/sequencing logic drives addresses, opcode, write enable and write data, and consumes the read data, ALU result and flag.

## Interface
- No parameters. Widths are fixed: 16-bit data, 8 registers, 3-bit register address, 4-bit opcode.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- address_a  input  3  read port A register index; also the write destination index.
- address_b  input  3  read port B register index.
- write_enable  input  1  writes write_data into register[address_a] at the next rising clk.
- write_data  input  16  data to write.
- opcode  input  4  ALU operation select (instruction[15:12]).
- data_a  output  16  register[address_a], combinational.
- data_b  output  16  register[address_b], combinational.
- alu_result  output  16  combinational ALU result of data_a op data_b.
- alu_zero  output  1  combinational; 1 when alu_result == 16'h0000.
- zero_flag  output  1  registered zero status flag.

## Operation
- Register file: 8 x 16-bit registers r0..r7. All eight are writable; r0 is not hardwired.
- Write: on rising clk with write_enable=1, register[address_a] <= write_data. With write_enable=0, no register changes.
- Reads: data_a and data_b are asynchronous reads of the current register contents. There is no write-to-read bypass.
- Both read ports may address the same register. Both then return the same value.
- ALU ops on a=data_a and b=data_b. All arithmetic is modulo 2^16 and carry/borrow are discarded.
  - 4'b0010 ADD: a + b.
  - 4'b0011 SUB: a - b.
  - 4'b0100 AND: a & b.
  - 4'b0101 OR: a | b.
  - 4'b0110 XOR: a ^ b.
  - 4'b0111 SLL: a << b[3:0].
  - All other opcodes (0000, 0001 load-immediate, 1000 jmp, 1100 br, 1111 out, unused): alu_result = 16'h0000.
- alu_zero = (alu_result == 0) for every opcode. It is therefore 1 for the non-ALU opcodes.
- Zero flag: on rising clk with opcode == 4'b0011 (SUB), zero_flag <= alu_zero.
  - This update happens regardless of write_enable.
  - zero_flag holds its value for all other opcodes.
- The processor writes alu_result back via write_data/write_enable for ADD/SUB. Loads are done by driving the immediate on write_data. The block does not select write data itself.

## Timing
- Reset: rst_n low immediately clears r0..r7 to 16'h0000 and zero_flag to 0, independent of clk.
  - With all registers zero, data_a = data_b = 0, and for ADD alu_result = 0 and alu_zero = 1.
  - Reset asserted mid-operation overrides any pending write in that cycle.
  - After rst_n deasserts, the first rising clk may write.
- Write latency is 1 clk. New data is visible on data_a/data_b immediately after the write edge.
- Same-cycle read of the register being written returns the old value until the edge.
- alu_result, alu_zero, data_a and data_b have zero-cycle latency: purely combinational from address/opcode/register state.
- zero_flag latency is 1 clk after a SUB. It reflects the operands present at that edge.
- A SUB with write_enable=1 writing register[address_a] uses pre-edge operands for both the written value and the flag.

## Test plan
- Reset: hold rst_n=0 with write_enable=1 and clock running -> all eight registers read 0x0000, zero_flag=0. Release -> write r3=0x00AB, then read address_a=3 -> 0x00AB.
- Write/read all registers: write r_i = 0x1111*i for i=0..7 -> each read on both ports matches. A write with write_enable=0 leaves contents unchanged.
- ADD wrap: r1=0xFFFF, r2=0x0002, opcode ADD, address_a=1, address_b=2 -> alu_result=0x0001, alu_zero=0. Write-back with write_enable=1 -> r1=0x0001 after the edge.
- SUB and flag:
  - r4=0x0005, r5=0x0005, SUB -> alu_result=0, alu_zero=1, zero_flag=1 after the edge.
  - Then ADD with nonzero result -> zero_flag stays 1.
  - Then SUB of 0x0005-0x0003 -> zero_flag=0.
- Logic/shift/other: a=0x0F0F, b=0x00F3 ->
  - AND 0x0003.
  - OR 0x0FFF.
  - XOR 0x0FFC.
  - SLL 0x7878.
  - opcode 1111 -> alu_result 0x0000, alu_zero=1.
- Same-address and async reset mid-write: address_a=address_b=6, write 0x1234 -> both ports show the old value before the edge and 0x1234 after. Pulse rst_n low between edges -> r6=0 immediately.
